// File: rtl/fwd_hazard_sb.sv
// Operand forwarding, load-use and long-latency scoreboard hazard unit; optional stall counter under FWD_HAZARD_PERF_EN.
// Latency: fwd_sel/stall combinational (0 cycles); pending updates 1 cycle after iss_en/ret_en.
// Backpressure: stall holds IF/ID and bubbles ID/EX; iss_en is never gated here, upstream must honour stall.
module fwd_hazard_sb #(
    parameter int NREAD  = 2,
    parameter int NSTAGE = 2,
    parameter int RW     = 5,
    parameter int SW     = $clog2(NSTAGE + 1),
    localparam int NREG  = 2 ** RW
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [NREAD-1:0]     rd_en,
    input  logic [NREAD*RW-1:0]  rsel,
    input  logic [NSTAGE-1:0]    st_wen,
    input  logic [NSTAGE*RW-1:0] st_wsel,
    input  logic [NSTAGE-1:0]    st_rdy,
    input  logic                 iss_en,
    input  logic [RW-1:0]        iss_wsel,
    input  logic                 ret_en,
    input  logic [RW-1:0]        ret_wsel,
    output logic [NREAD*SW-1:0]  fwd_sel,
    output logic                 stall,
    output logic [NREG-1:0]      pending,
    output logic [31:0]          stall_cnt
);

    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_pending_nxt;
    logic [NREG-1:0] w_iss_mask;
    logic [NREG-1:0] w_ret_mask;
    logic            w_stall_ld;
    logic            w_stall_sb;
    logic            w_stall_waw;

    // Per operand: youngest matching stage wins; flag load-use and scoreboard hazards.
    always_comb begin
        logic [RW-1:0] w_idx;
        logic [SW-1:0] w_sel;
        logic          w_hit;
        logic          w_hit_rdy;
        fwd_sel    = '0;
        w_stall_ld = 1'b0;
        w_stall_sb = 1'b0;
        for (int k = 0; k < NREAD; k++) begin
            w_idx     = rsel[k*RW +: RW];
            w_sel     = '0;
            w_hit     = 1'b0;
            w_hit_rdy = 1'b0;
            // Walk oldest to youngest so the lowest-numbered match is the last one written.
            for (int s = NSTAGE - 1; s >= 0; s--) begin
                if (rd_en[k] && st_wen[s] && (st_wsel[s*RW +: RW] == w_idx) && (w_idx != '0)) begin
                    w_sel     = SW'(s + 1);
                    w_hit     = 1'b1;
                    w_hit_rdy = st_rdy[s];
                end
            end
            fwd_sel[k*SW +: SW] = w_sel;
            if (w_hit && !w_hit_rdy) begin
                w_stall_ld = 1'b1;
            end
            // A ready in-pipe producer supersedes the in-flight scoreboard entry.
            if (rd_en[k] && r_pending[w_idx] && !(w_hit && w_hit_rdy)) begin
                w_stall_sb = 1'b1;
            end
        end
    end

    // WAW on an in-flight destination, unless that destination retires this same cycle.
    always_comb begin
        w_stall_waw = iss_en && r_pending[iss_wsel] && !(ret_en && (ret_wsel == iss_wsel));
        stall       = w_stall_ld || w_stall_sb || w_stall_waw;
    end

    // Next scoreboard state: clear retires, then set issues so a same-index set wins; r0 never set.
    always_comb begin
        w_iss_mask = '0;
        w_ret_mask = '0;
        if (iss_en && (iss_wsel != '0)) begin
            w_iss_mask[iss_wsel] = 1'b1;
        end
        if (ret_en) begin
            w_ret_mask[ret_wsel] = 1'b1;
        end
        w_pending_nxt = (r_pending & ~w_ret_mask) | w_iss_mask;
    end

    // Scoreboard register; reset drops every in-flight op.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign pending = r_pending;

`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of edges at which the pipe was stalled.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fwd_hazard_sb.sv
// Bench for fwd_hazard_sb with default parameters (NREAD=2, NSTAGE=2, RW=5).
// Expected fwd_sel/stall are queued when stimulus is applied and compared when sampled.
// pending and stall_cnt are checked against a bench-side model of the scoreboard and stall count.
module tb_fwd_hazard_sb;

    logic        CLK;
    logic        nRST;
    logic [1:0]  rd_en;
    logic [9:0]  rsel;
    logic [1:0]  st_wen;
    logic [9:0]  st_wsel;
    logic [1:0]  st_rdy;
    logic        iss_en;
    logic [4:0]  iss_wsel;
    logic        ret_en;
    logic [4:0]  ret_wsel;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic [31:0] pending;
    logic [31:0] stall_cnt;

    typedef struct packed {
        logic [3:0] fwd;
        logic       stall;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 0;
    logic [31:0] exp_cnt_out;

    fwd_hazard_sb dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .rd_en     (rd_en),
        .rsel      (rsel),
        .st_wen    (st_wen),
        .st_wsel   (st_wsel),
        .st_rdy    (st_rdy),
        .iss_en    (iss_en),
        .iss_wsel  (iss_wsel),
        .ret_en    (ret_en),
        .ret_wsel  (ret_wsel),
        .fwd_sel   (fwd_sel),
        .stall     (stall),
        .pending   (pending),
        .stall_cnt (stall_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    task automatic set_idle();
        rd_en = '0; rsel = '0; st_wen = '0; st_wsel = '0; st_rdy = '0;
        iss_en = 1'b0; iss_wsel = '0; ret_en = 1'b0; ret_wsel = '0;
    endtask

    task automatic expect_out(input logic [3:0] fwd, input logic stl);
        exp_t x;
        x.fwd   = fwd;
        x.stall = stl;
        sb_q.push_back(x);
    endtask

    // Advance one edge; the model counts the edge if the expected stall was high.
    task automatic tick(input logic stl);
        @(posedge CLK);
        if (stl && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        set_idle();
        nRST = 1'b0;
        expect_out(4'h0, 1'b0);
        #2;
        e = sb_q.pop_front();
        checks++;
        if (fwd_sel !== e.fwd || stall !== e.stall) begin
            errors++;
            $display("FAIL reset_outs fwd_sel=%h stall=%b want fwd_sel=%h stall=%b", fwd_sel, stall, e.fwd, e.stall);
        end
        checks++;
        if (pending !== 32'h0 || stall_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_state pending=%h stall_cnt=%0d want 0/0", pending, stall_cnt);
        end
        @(negedge CLK);
        nRST = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_priority();
        set_idle();
        rd_en = 2'b01; rsel = {5'd0, 5'd5};
        st_wen = 2'b11; st_wsel = {5'd5, 5'd5}; st_rdy = 2'b11;
        expect_out(4'b0001, 1'b0);
        #1;
        e = sb_q.pop_front();
        checks++;
        if (fwd_sel !== e.fwd || stall !== e.stall) begin
            errors++;
            $display("FAIL prio_both fwd_sel=%h stall=%b want fwd_sel=%h stall=%b", fwd_sel, stall, e.fwd, e.stall);
        end
        tick(1'b0);
        st_wen = 2'b10;
        expect_out(4'b0010, 1'b0);
        #1;
        e = sb_q.pop_front();
        checks++;
        if (fwd_sel !== e.fwd || stall !== e.stall) begin
            errors++;
            $display("FAIL prio_stage2 fwd_sel=%h stall=%b want fwd_sel=%h stall=%b", fwd_sel, stall, e.fwd, e.stall);
        end
        tick(1'b0);
    endtask

    task automatic test_r0_rden();
        // op0 reads r0 (never forwarded); op1 matches r7 but is disabled, then enabled.
        set_idle();
        rd_en = 2'b01; rsel = {5'd7, 5'd0};
        st_wen = 2'b01; st_wsel = {5'd0, 5'd0}; st_rdy = 2'b11;
        expect_out(4'b0000, 1'b0);
        #1;
        e = sb_q.pop_front();
        checks++;
        if (fwd_sel !== e.fwd || stall !== e.stall) begin
            errors++;
            $display("FAIL r0_nofwd fwd_sel=%h stall=%b want fwd_sel=%h stall=%b", fwd_sel, stall, e.fwd, e.stall);
        end
        tick(1'b0);
        for (int en = 0; en < 2; en++) begin
            rd_en = {en[0], 1'b0}; rsel = {5'd7, 5'd0};
            st_wen = 2'b01; st_wsel = {5'd0, 5'd7};
            expect_out(en[0] ? 4'b0100 : 4'b0000, 1'b0);
            #1;
            e = sb_q.pop_front();
            checks++;
            if (fwd_sel !== e.fwd || stall !== e.stall) begin
                errors++;
                $display("FAIL rd_en1_%0d fwd_sel=%h stall=%b want fwd_sel=%h stall=%b", en, fwd_sel, stall, e.fwd, e.stall);
            end
            tick(1'b0);
        end
    endtask

    task automatic test_load_use();
        set_idle();
        rd_en = 2'b10; rsel = {5'd8, 5'd0};
        st_wen = 2'b01; st_wsel = {5'd0, 5'd8}; st_rdy = 2'b10;
        expect_out(4'b0100, 1'b1);
        #1;
        e = sb_q.pop_front();
        checks++;
        if (fwd_sel !== e.fwd || stall !== e.stall) begin
            errors++;
            $display("FAIL load_use fwd_sel=%h stall=%b want fwd_sel=%h stall=%b", fwd_sel, stall, e.fwd, e.stall);
        end
        tick(1'b1);
        st_wen = 2'b10; st_wsel = {5'd8, 5'd0}; st_rdy = 2'b10;
        expect_out(4'b1000, 1'b0);
        #1;
        e = sb_q.pop_front();
        checks++;
        if (fwd_sel !== e.fwd || stall !== e.stall) begin
            errors++;
            $display("FAIL load_use_done fwd_sel=%h stall=%b want fwd_sel=%h stall=%b", fwd_sel, stall, e.fwd, e.stall);
        end
        tick(1'b0);
    endtask

    task automatic test_scoreboard();
        set_idle();
        iss_en = 1'b1; iss_wsel = 5'd12;
        tick(1'b0);
        set_idle();
        checks++;
        if (pending[12] !== 1'b1) begin
            errors++;
            $display("FAIL sb_issue pending12=%b want 1", pending[12]);
        end
        // Five stalled reads, then the retire cycle which still stalls.
        for (int c = 0; c < 6; c++) begin
            rd_en = 2'b01; rsel = {5'd0, 5'd12};
            ret_en = (c == 5); ret_wsel = 5'd12;
            expect_out(4'b0000, 1'b1);
            #1;
            e = sb_q.pop_front();
            checks++;
            if (fwd_sel !== e.fwd || stall !== e.stall) begin
                errors++;
                $display("FAIL sb_stall_%0d fwd_sel=%h stall=%b want fwd_sel=%h stall=%b", c, fwd_sel, stall, e.fwd, e.stall);
            end
            tick(1'b1);
        end
        ret_en = 1'b0;
        expect_out(4'b0000, 1'b0);
        #1;
        e = sb_q.pop_front();
        checks++;
        if (fwd_sel !== e.fwd || stall !== e.stall || pending[12] !== 1'b0) begin
            errors++;
            $display("FAIL sb_release fwd_sel=%h stall=%b pending12=%b want fwd_sel=%h stall=%b pending12=0",
                     fwd_sel, stall, pending[12], e.fwd, e.stall);
        end
`ifdef FWD_HAZARD_PERF_EN
        exp_cnt_out = exp_cnt;
`else
        exp_cnt_out = 32'h0;
`endif
        checks++;
        if (stall_cnt !== exp_cnt_out) begin
            errors++;
            $display("FAIL sb_stall_cnt stall_cnt=%0d want %0d", stall_cnt, exp_cnt_out);
        end
        tick(1'b0);
    endtask

    task automatic test_simultaneous();
        set_idle();
        iss_en = 1'b1; iss_wsel = 5'd3; ret_en = 1'b1; ret_wsel = 5'd3;
        expect_out(4'b0000, 1'b0);
        #1;
        e = sb_q.pop_front();
        checks++;
        if (stall !== e.stall) begin
            errors++;
            $display("FAIL iss_ret_same stall=%b want %b", stall, e.stall);
        end
        tick(1'b0);
        set_idle();
        iss_en = 1'b1; iss_wsel = 5'd4;
        tick(1'b0);
        checks++;
        if (pending !== 32'h0000_0018) begin
            errors++;
            $display("FAIL set_wins pending=%h want 00000018", pending);
        end
        // Re-issue r4 while pending: WAW stall; then with same-cycle retire of r4: no stall.
        for (int r = 0; r < 2; r++) begin
            iss_en = 1'b1; iss_wsel = 5'd4; ret_en = r[0]; ret_wsel = 5'd4;
            expect_out(4'b0000, ~r[0]);
            #1;
            e = sb_q.pop_front();
            checks++;
            if (stall !== e.stall) begin
                errors++;
                $display("FAIL waw_%0d stall=%b want %b", r, stall, e.stall);
            end
            tick(~r[0]);
        end
        set_idle();
        ret_en = 1'b1; ret_wsel = 5'd9;
        tick(1'b0);
        set_idle();
        iss_en = 1'b1; iss_wsel = 5'd0;
        tick(1'b0);
        set_idle();
        checks++;
        if (pending !== 32'h0000_0018) begin
            errors++;
            $display("FAIL ret_idle_r0 pending=%h want 00000018", pending);
        end
        // Read of pending r3: stage-1 ready producer bypasses, not-ready one stalls.
        for (int rdy = 1; rdy >= 0; rdy--) begin
            rd_en = 2'b01; rsel = {5'd0, 5'd3};
            st_wen = 2'b01; st_wsel = {5'd0, 5'd3}; st_rdy = {1'b0, rdy[0]};
            expect_out(4'b0001, ~rdy[0]);
            #1;
            e = sb_q.pop_front();
            checks++;
            if (fwd_sel !== e.fwd || stall !== e.stall) begin
                errors++;
                $display("FAIL sb_bypass_rdy%0d fwd_sel=%h stall=%b want fwd_sel=%h stall=%b", rdy, fwd_sel, stall, e.fwd, e.stall);
            end
            tick(~rdy[0]);
        end
        set_idle();
    endtask

    task automatic test_async_reset();
        set_idle();
        nRST = 1'b0;
        #1;
        nRST = 1'b1;
        exp_cnt = 0;
        @(negedge CLK);
        iss_en = 1'b1; iss_wsel = 5'd12;
        tick(1'b0);
        set_idle();
        rd_en = 2'b01; rsel = {5'd0, 5'd12};
        for (int c = 0; c < 7; c++) tick(1'b1);
        set_idle();
`ifdef FWD_HAZARD_PERF_EN
        exp_cnt_out = exp_cnt;
`else
        exp_cnt_out = 32'h0;
`endif
        #1;
        checks++;
        if (pending[12] !== 1'b1 || stall_cnt !== exp_cnt_out) begin
            errors++;
            $display("FAIL pre_reset pending12=%b stall_cnt=%0d want 1/%0d", pending[12], stall_cnt, exp_cnt_out);
        end
        #1;
        nRST = 1'b0;
        #1;
        checks++;
        if (pending !== 32'h0 || stall_cnt !== 32'h0) begin
            errors++;
            $display("FAIL async_reset pending=%h stall_cnt=%0d want 0/0", pending, stall_cnt);
        end
        #1;
        nRST = 1'b1;
        exp_cnt = 0;
        @(negedge CLK);
        ret_en = 1'b1; ret_wsel = 5'd12;
        tick(1'b0);
        set_idle();
        rd_en = 2'b01; rsel = {5'd0, 5'd12};
        expect_out(4'b0000, 1'b0);
        #1;
        e = sb_q.pop_front();
        checks++;
        if (stall !== e.stall || pending !== 32'h0) begin
            errors++;
            $display("FAIL late_retire stall=%b pending=%h want stall=%b pending=0", stall, pending, e.stall);
        end
        tick(1'b0);
        set_idle();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_r0_rden();
        test_load_use();
        test_scoreboard();
        test_simultaneous();
        test_async_reset();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain left=%0d want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_sb.md
# fwd_hazard_sb

Parametrised forwarding and hazard unit for the pipelined datapath. It generalises the two-stage, two-operand forward unit to `NREAD` source operands and `NSTAGE` forwarding stages. It adds load-use detection and a register scoreboard for variable-latency units such as the multiplier/divider and the load-miss path. It sits beside the ID/EX latch and drives the operand mux selects and the pipeline stall.

## Interface
- `NREAD`, default 2: number of source operands checked.
- `NSTAGE`, default 2: forwarding stages; stage 1 is youngest (EX/MEM), stage `NSTAGE` is oldest (MEM/WB).
- `RW`, default 5: register index width; `NREG = 2**RW`.
- `SW`, default `$clog2(NSTAGE+1)`: forward-select width.
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `rd_en` in `NREAD`: operand k is actually read.
- `rsel` in `NREAD*RW`: operand k index in slice k.
- `st_wen` in `NSTAGE`: stage s will write the register file.
- `st_wsel` in `NSTAGE*RW`: stage s destination.
- `st_rdy` in `NSTAGE`: stage s result is available now; 0 for a load still in EX/MEM.
- `iss_en` in 1 and `iss_wsel` in `RW`: a long-latency op issues, with this destination.
- `ret_en` in 1 and `ret_wsel` in `RW`: a long-latency op completes, with this destination.
- `fwd_sel` out `NREAD*SW`: per operand, 0 = register file, s = stage s.
- `stall` out 1: hold IF/ID and bubble ID/EX.
- `pending` out `NREG`: scoreboard bits.
- `stall_cnt` out 32: stall-cycle counter.

## Operation
- **Source match.** Stage s matches operand k when all of these hold: `rd_en[k]`, `st_wen[s]`, `st_wsel[s]==rsel[k]`, and `rsel[k]!=0`.
- **Forward select.** `fwd_sel[k]` is the lowest-numbered matching stage, so the youngest producer wins. With no match, `fwd_sel[k]` is 0.
- **Load-use hazard.** If the selected stage has `st_rdy=0`, `stall=1`. `fwd_sel` still reports that stage.
- **Scoreboard hazard.** `stall=1` if `rd_en[k]` and `pending[rsel[k]]` for any k, unless a stage match with `st_rdy=1` exists for that operand.
- **Issue conflict.** `stall=1` if `iss_en` and `pending[iss_wsel]` and not (`ret_en` and `ret_wsel==iss_wsel`). This is a WAW hazard on an in-flight destination.
- **Scoreboard update at the clock edge.**
  - Set `pending[iss_wsel]` on `iss_en`.
  - Clear `pending[ret_wsel]` on `ret_en`.
  - If issue and retire hit the same index in the same cycle, set wins.
  - Retiring an index that is not pending is ignored.
  - Index 0 is never set.
- **Stall effect.** The scoreboard does not gate `iss_en` itself. The stall is the mechanism that prevents upstream from issuing.
- **Reset.** `nRST=0` asynchronously clears `pending` to 0 and `stall_cnt` to 0. This includes reset mid-operation, when ops are in flight; their later `ret_en` is ignored. Combinational outputs follow their inputs during reset.

## Timing
- `fwd_sel` and `stall` are combinational from the inputs and the registered `pending`, with zero latency.
- `pending` changes one cycle after `iss_en`/`ret_en`. Therefore a dependent read stalls through the retire cycle and proceeds on the next cycle, reading the register file.
- A dependent read in the cycle of `iss_en` does not see the new bit. Upstream instead sees it through stage 1 `st_wen` with `st_rdy=0`.
- `stall_cnt` increments at every edge where `stall=1`. It saturates at `32'hFFFF_FFFF`.

## Configuration
- **`FWD_HAZARD_PERF_EN` defined:** `stall_cnt` is implemented as described.
- **`FWD_HAZARD_PERF_EN` undefined:** `stall_cnt` is tied to `32'h0` and no counter flops are instantiated. Every other behaviour is identical.

## Test plan
- **Priority.** `rsel0=5` with stage1 and stage2 both writing r5, both `st_rdy=1` → `fwd_sel0=1`, `stall=0`. Drop the stage1 write → `fwd_sel0=2`.
- **r0 and `rd_en`.** `rsel0=0` with stage1 writing r0 → `fwd_sel0=0`. `rd_en1=0` with a matching stage → `fwd_sel1=0`.
- **Load-use.** Stage1 writes r8 with `st_rdy=0`, `rsel1=8` → `stall=1`, `fwd_sel1=1`. Next cycle the stage-2 match has `st_rdy=1` → `stall=0`, `fwd_sel1=2`.
- **Scoreboard.** `iss_en` r12 → `pending[12]=1` next cycle. A read of r12 stalls for 5 cycles. `ret_en` r12 keeps `stall=1` in the retire cycle and gives `stall=0` next cycle. `stall_cnt` equals the stall cycles with the macro defined, and 0 without it.
- **Simultaneous events.** Issue and retire of r3 in the same cycle → `pending[3]=1`, no stall. Issue r4 while r4 is pending → `stall=1`. Retire r9 when not pending → no change.
- **Async reset mid-op.** With `pending[12]=1` and `stall_cnt=7`, pulse `nRST` low between edges → `pending=0` and `stall_cnt=0` immediately. A later `ret_en` r12 has no effect.
